clk_div_ctrl: RTL
=================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time controller for the fabric clock divider on the 33.8688 MHz system clock.
//  - Generates divided clock clk_N with a programmable half-period, plus a 1-cycle tick per rising edge.
//  - Start/stop sequencing is glitch-free; a stopped clk_N always rests low.
//  - A new half-period can be loaded through a valid/ready handshake while running.
//  - Sits between the test-control FSM and the timing-dependent flash/LED test logic.
// PARAMETERS
//  CW            25        width of half-period count and config bus
//  DEFAULT_HALF  16934400  half-period loaded at reset (1 Hz at 33.8688 MHz)
// PORTS
//  clk        in   1   system clock, 33.8688 MHz; only clock in block
//  rst        in   1   reset, asynchronous, active-low
//  start      in   1   level/pulse; begin generation (honoured in IDLE only)
//  stop       in   1   request glitch-free stop
//  cfg_valid  in   1   new half-period offered
//  cfg_half   in   CW  requested half-period in clk cycles; 0 treated as 1
//  cfg_ready  out  1   config accepted when cfg_valid&cfg_ready
//  busy       out  1   high whenever state != IDLE
//  clk_N      out  1   divided clock, registered
//  tick       out  1   1-cycle pulse, high in first cycle clk_N reads 1
// BEHAVIOUR
//  Reset (rst=0, async)
//   - clk_N=0, tick=0, busy=0, cfg_ready=1, count=0, half=DEFAULT_HALF, state=IDLE.
//   - Takes effect mid-operation too; any pending config or stop is discarded.
//  States: IDLE, RUN, PEND (config waiting for next toggle point)
//  Toggle point: count==half_eff-1, where half_eff = (half==0) ? 1 : half.
//   - At a toggle point: clk_N<=~clk_N, count<=0. Otherwise count<=count+1 (RUN/PEND only).
//   - tick<=1 exactly when clk_N goes 0->1; else tick<=0.
//  IDLE
//   - count held at 0, clk_N=0.
//   - start=1 & stop=0 -> RUN; clk_N rises half_eff cycles later; steady period is 2*half_eff.
//   - Accepted config loads half immediately; state stays IDLE.
//   - start&stop together -> stays IDLE.
//  RUN
//   - Accepted config latches into shadow reg -> PEND. Current phase finishes with old half;
//     the new half governs from the cycle after the toggle point.
//  PEND
//   - cfg_ready=0.
//   - At toggle point: half<=shadow, then -> RUN (cfg_ready=1 next cycle).
//  Stop (RUN or PEND)
//   - clk_N=0: -> IDLE next cycle, count<=0.
//   - clk_N=1: stop latched; high phase completes at full length, then clk_N<=0 and -> IDLE.
//   - A pending shadow config is applied at that final toggle.
//   - stop has priority over start; start outside IDLE is ignored.
//  Widths and counter rules
//   - count and half are CW bits, unsigned. Count never exceeds half_eff-1, so no wrap.
//   - Lowering half below count+1 while RUN is safe because the new half applies only after count resets.
// CONFIGURATION
//  PULSE_CNT_EN defined: adds burst mode.
//   - Extra ports: burst_len in CW, done out 1.
//   - burst_len sampled at start; 0 = free-run.
//   - Counts ticks; after burst_len-th tick, behaves as stop (ends after that high phase).
//   - done pulses 1 cycle on entry to IDLE from burst end. done reset value 0.
//  PULSE_CNT_EN undefined: no extra ports, no counter; free-run until stop.
// TESTING (benches override DEFAULT_HALF=4)
//  1. Assert rst=0 mid-run -> same cycle clk_N=0, tick=0, busy=0, cfg_ready=1; release -> IDLE.
//  2. start 1 cycle -> clk_N rises 4 cycles later, period 8, tick every 8 cycles, busy=1.
//  3. cfg_half=2 offered in middle of high phase -> cfg_ready=0 until toggle; that phase lasts 4,
//     subsequent phases 2 (period 4).
//  4. stop at 2nd cycle of high phase -> clk_N stays high full 4 cycles, then 0, busy=0;
//     stop during low phase -> busy=0 next cycle, clk_N stays 0.
//  5. cfg_half=0 in IDLE, then start -> clk_N toggles every cycle, tick every 2 cycles.
//  6. PULSE_CNT_EN, burst_len=3, start -> exactly 3 ticks, clk_N low after 3rd high phase,
//     done=1 one cycle, busy=0.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for the fabric clock divider.
// Produces a registered divided clock clk_N with a programmable half-period,
// a one-cycle tick on every clk_N rising edge, glitch-free start/stop, and a
// valid/ready port for loading a new half-period while running.
// Optional feature macro: PULSE_CNT_EN (burst mode: burst_len / done ports).
module clk_div_ctrl #(
    parameter int          CW           = 25,
    parameter int unsigned DEFAULT_HALF = 32'd16934400
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_half,
`ifdef PULSE_CNT_EN
    input  logic [CW-1:0] burst_len,
    output logic          done,
`endif
    output logic          cfg_ready,
    output logic          busy,
    output logic          clk_N,
    output logic          tick
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [CW-1:0] half, half_nx;
    logic [CW-1:0] shadow, shadow_nx;
    logic [CW-1:0] half_eff;
    logic [CW-1:0] pend_val;
    logic          clk_n_nx, tick_nx;
    logic          stop_pend, stop_pend_nx;
    logic          at_toggle, accept, stop_now, pend_valid;
`ifdef PULSE_CNT_EN
    logic [CW-1:0] burst_reg, burst_nx;
    logic [CW-1:0] tick_cnt, tick_cnt_nx;
    logic          burst_hit, burst_hit_nx;
    logic          done_nx;
`endif

    // Handshake and status decode straight from the current state.
    always_comb begin
        half_eff  = (half == '0) ? CW'(1) : half;
        at_toggle = (count == half_eff - CW'(1));
        cfg_ready = (state != ST_PEND);
        busy      = (state != ST_IDLE);
        accept    = cfg_valid & cfg_ready;
        stop_now  = stop | stop_pend;
    end

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nx     = state;
        count_nx     = count;
        half_nx      = half;
        shadow_nx    = shadow;
        clk_n_nx     = clk_N;
        tick_nx      = 1'b0;
        stop_pend_nx = stop_pend;
        pend_valid   = (state == ST_PEND);
        pend_val     = shadow;
`ifdef PULSE_CNT_EN
        burst_nx     = burst_reg;
        tick_cnt_nx  = tick_cnt;
        burst_hit_nx = burst_hit;
        done_nx      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                count_nx     = '0;
                clk_n_nx     = 1'b0;
                stop_pend_nx = 1'b0;
                if (accept) half_nx = cfg_half;
                if (start && !stop) begin
                    state_nx = ST_RUN;
`ifdef PULSE_CNT_EN
                    burst_nx     = burst_len;
                    tick_cnt_nx  = '0;
                    burst_hit_nx = 1'b0;
`endif
                end
            end
            ST_RUN, ST_PEND: begin
                // A config accepted while running waits for the next toggle point.
                if (state == ST_RUN && accept) begin
                    shadow_nx  = cfg_half;
                    state_nx   = ST_PEND;
                    pend_valid = 1'b1;
                    pend_val   = cfg_half;
                end
                if (stop_now && !clk_N) begin
                    // Low phase: stopping now cannot produce a runt pulse.
                    state_nx     = ST_IDLE;
                    count_nx     = '0;
                    stop_pend_nx = 1'b0;
                    if (pend_valid) half_nx = pend_val;
                end else if (at_toggle) begin
                    count_nx = '0;
                    clk_n_nx = ~clk_N;
                    tick_nx  = ~clk_N;
                    if (state == ST_PEND) begin
                        half_nx  = shadow;
                        state_nx = ST_RUN;
                    end
                    if (clk_N && stop_now) begin
                        // Final falling edge after a deferred stop.
                        state_nx     = ST_IDLE;
                        stop_pend_nx = 1'b0;
                        if (pend_valid) half_nx = pend_val;
`ifdef PULSE_CNT_EN
                        done_nx = burst_hit;
`endif
                    end
`ifdef PULSE_CNT_EN
                    if (!clk_N) begin
                        tick_cnt_nx = tick_cnt + CW'(1);
                        if (burst_reg != '0 && tick_cnt + CW'(1) == burst_reg) begin
                            stop_pend_nx = 1'b1;
                            burst_hit_nx = 1'b1;
                        end
                    end
`endif
                end else begin
                    count_nx = count + CW'(1);
                    // High phase: remember the stop and let the phase complete.
                    if (stop && clk_N) stop_pend_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                count_nx = '0;
                clk_n_nx = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            half      <= CW'(DEFAULT_HALF);
            shadow    <= '0;
            clk_N     <= 1'b0;
            tick      <= 1'b0;
            stop_pend <= 1'b0;
`ifdef PULSE_CNT_EN
            burst_reg <= '0;
            tick_cnt  <= '0;
            burst_hit <= 1'b0;
            done      <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            half      <= half_nx;
            shadow    <= shadow_nx;
            clk_N     <= clk_n_nx;
            tick      <= tick_nx;
            stop_pend <= stop_pend_nx;
`ifdef PULSE_CNT_EN
            burst_reg <= burst_nx;
            tick_cnt  <= tick_cnt_nx;
            burst_hit <= burst_hit_nx;
            done      <= done_nx;
`endif
        end
    end

endmodule
